// File: rtl/upsampler.sv
// Integer-factor interpolator: one input sample per valid/ready handshake
// becomes r output samples on r consecutive clocks. Output phase 0 carries
// the sample; phases 1..r-1 are zero-stuffed by default.
// Build option: define UPSAMPLER_ZOH_EN for zero-order hold, where phases
// 1..r-1 repeat the sample instead of driving zero.
module upsampler #(
  parameter int dw = 8,
  parameter int r  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [dw-1:0] data_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [dw-1:0] data_out,
  output logic          dv,
  output logic          out_first
);

  localparam int PW = $clog2(r);
  localparam logic [PW-1:0] LAST_PHASE = PW'(r - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [dw-1:0] sample_q, sample_d;
  logic [dw-1:0] data_q, data_d;
  logic          dv_q, dv_d;
  logic          first_q, first_d;
  logic          accept;
  logic [dw-1:0] stuff_value;

`ifdef UPSAMPLER_ZOH_EN
  assign stuff_value = sample_q;
`else
  assign stuff_value = '0;
`endif

  // Ready depends only on registered state (plus reset), never on in_valid.
  assign in_ready  = !reset && ((state_q == IDLE) || (phase_q == LAST_PHASE));
  assign accept    = in_valid && in_ready;

  assign data_out  = data_q;
  assign dv        = dv_q;
  assign out_first = first_q;

  // Next-state: accept starts a burst at phase 0 (also back-to-back on the
  // last phase); otherwise step through the burst or drop back to idle.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    sample_d = sample_q;
    data_d   = data_q;
    dv_d     = 1'b0;
    first_d  = 1'b0;
    if (accept) begin
      state_d  = EMIT;
      phase_d  = '0;
      sample_d = data_in;
      data_d   = data_in;
      dv_d     = 1'b1;
      first_d  = 1'b1;
    end else if (state_q == EMIT) begin
      if (phase_q != LAST_PHASE) begin
        phase_d = phase_q + 1'b1;
        data_d  = stuff_value;
        dv_d    = 1'b1;
      end else begin
        state_d = IDLE;
        phase_d = '0;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      sample_q <= '0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
      data_q   <= data_d;
      dv_q     <= dv_d;
      first_q  <= first_d;
    end
  end

endmodule
